// File: rtl/egress_pkg.sv
`default_nettype none
// ============================================================================
// Module      : egress_pkg
// Description : Shared port count, slot-state encoding and port-word type for
//               the egress merger.
// Revision    : 1.0 - initial release
// ============================================================================
package egress_pkg;

    localparam int NUM_PORTS     = 4;
    localparam int PORT_W        = 2;
    localparam int PKG_PAYLOAD_W = 16;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic [PORT_W-1:0]        port;
        logic [PKG_PAYLOAD_W-1:0] payload;
    } port_word_t;

endpackage
`default_nettype wire

// File: rtl/egress_fifo.sv
`default_nettype none
// ============================================================================
// Module      : egress_fifo
// Description : Synchronous per-port FIFO with combinational head read.
// Revision    : 1.0 - initial release
// ============================================================================
module egress_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_DEPTH_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    // Guard both sides so a misbehaving caller cannot corrupt the count.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/egress_merger.sv
`default_nettype none
// ============================================================================
// Module      : egress_merger
// Description : Buffers four routed port streams and merges them round-robin
//               onto one valid/ready stream tagged with the source port.
// Revision    : 1.0 - initial release
// ============================================================================
module egress_merger
    import egress_pkg::*;
#(
    parameter int PAYLOAD_W  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           in_valid,
    input  logic [PAYLOAD_W-1:0] in_data_0,
    input  logic [PAYLOAD_W-1:0] in_data_1,
    input  logic [PAYLOAD_W-1:0] in_data_2,
    input  logic [PAYLOAD_W-1:0] in_data_3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           out_port,
    output logic [3:0]           fifo_full,
    output logic [DROP_W-1:0]    drop_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [PAYLOAD_W-1:0]            w_in_data [NUM_PORTS];
    logic [PAYLOAD_W-1:0]            w_head    [NUM_PORTS];
    logic [NUM_PORTS-1:0]            w_push;
    logic [NUM_PORTS-1:0]            w_pop;
    logic [NUM_PORTS-1:0]            w_drop;
    logic [NUM_PORTS-1:0]            w_empty;
    logic [NUM_PORTS-1:0][CW-1:0]    w_count;
    logic                            w_unused_count;

    slot_state_t          r_state;
    slot_state_t          w_state_next;
    logic [PAYLOAD_W-1:0] r_out_data;
    logic [PORT_W-1:0]    r_out_port;
    logic [PORT_W-1:0]    r_rr_last;
    logic [DROP_W-1:0]    r_drop;

    logic                 w_slot_free;
    logic                 w_grant_valid;
    logic [PORT_W-1:0]    w_grant_idx;
    logic                 w_load;
    logic [2:0]           w_drop_num;
    logic [DROP_W:0]      w_drop_sum;

    assign w_in_data[0] = in_data_0;
    assign w_in_data[1] = in_data_1;
    assign w_in_data[2] = in_data_2;
    assign w_in_data[3] = in_data_3;

    // Full is taken from the pre-edge count, so a same-cycle pop never rescues a push.
    assign w_push = in_valid & ~fifo_full;
    assign w_drop = in_valid & fifo_full;

    generate
        for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
            egress_fifo #(
                .WIDTH (PAYLOAD_W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_push[n]),
                .i_data  (w_in_data[n]),
                .i_pop   (w_pop[n]),
                .o_head  (w_head[n]),
                .o_full  (fifo_full[n]),
                .o_empty (w_empty[n]),
                .o_count (w_count[n])
            );
        end
    endgenerate

    assign w_unused_count = ^w_count;

    // Round-robin scan starting just after the last granted port.
    always_comb begin
        logic [PORT_W-1:0] cand;
        w_grant_valid = 1'b0;
        w_grant_idx   = r_rr_last;
        cand          = r_rr_last;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = r_rr_last + PORT_W'(i);
            if (!w_grant_valid && !w_empty[cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = cand;
            end
        end
    end

    assign w_slot_free = (r_state == SLOT_EMPTY) || out_ready;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_pop        = '0;
        if (w_slot_free) begin
            if (w_grant_valid) begin
                w_state_next         = SLOT_FULL;
                w_load               = 1'b1;
                w_pop[w_grant_idx]   = 1'b1;
            end else begin
                w_state_next = SLOT_EMPTY;
            end
        end
    end

    always_comb begin
        w_drop_num = '0;
        for (int n = 0; n < NUM_PORTS; n++) begin
            w_drop_num = w_drop_num + 3'(w_drop[n]);
        end
    end

    assign w_drop_sum = {1'b0, r_drop} + (DROP_W+1)'(w_drop_num);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SLOT_EMPTY;
            r_out_data <= '0;
            r_out_port <= '0;
            r_rr_last  <= PORT_W'(NUM_PORTS - 1);
            r_drop     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_out_data <= w_head[w_grant_idx];
                r_out_port <= w_grant_idx;
                r_rr_last  <= w_grant_idx;
            end
            // At most four drops per cycle, so one carry bit flags saturation.
            r_drop <= w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
        end
    end

    assign out_valid  = (r_state == SLOT_FULL);
    assign out_data   = r_out_data;
    assign out_port   = r_out_port;
    assign drop_count = r_drop;

endmodule
`default_nettype wire
